jtframe_inputs_mux: RTL
=======================

Name: jtframe_inputs_mux

Overview:
- Parametrised N-player input conditioner between the board controller inputs (keyboard/joystick/MC2 buttons) and the game core.
- Generalises the fixed 4-player, 2-button routing to 1..8 players and 1..6 buttons.
- Adds per-button autofire, opposite-direction (SOCD) cleaning, frame-based coin pulse stretching, a pause toggle and selectable output polarity.
- Sits beside jtframe_board; its outputs drive game_joystickN/game_coin/game_start/game_service/dip_pause.

Parameters:
PLAYERS, 4, number of player channels (1..8)
BUTTONS, 2, action buttons per player (1..6)
ACTIVE_LOW, 1, 1: game-side outputs are active low; 0: active high
AF_FRAMES, 2, frames per autofire half-period (1..15)
COIN_FRAMES, 4, frames a coin pulse is held at the game side (1..15)

Ports:
clk_sys  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active high
vs  in  1  vertical sync; each rising edge is one frame tick
board_joy  in  PLAYERS*16  active-high raw inputs. Per player: 0 right, 1 left, 2 down, 3 up, 4..4+BUTTONS-1 buttons, 14 service, 15 pause
board_coin  in  PLAYERS  active-high coin buttons
board_start  in  PLAYERS  active-high start buttons
af_en  in  BUTTONS  autofire enable per button index, shared by all players (OSD status)
game_joy  out  PLAYERS*10  per player: 0..3 directions, 4..9 buttons; unused buttons held inactive
game_coin  out  PLAYERS  stretched coin pulses
game_start  out  PLAYERS  start, registered
game_service  out  1  OR of all players' bit 14, registered
pause  out  1  pause state, toggled by player 1 bit 15

Behaviour:
- Reset: every game-side output goes to its inactive level (all ones if ACTIVE_LOW, else zeros); pause=0; autofire phase, frame counters and coin counters cleared; vs edge detector loaded with current vs so no spurious tick follows reset.
- Polarity: all internal logic is active high; inversion is applied only at the output registers.
- Latency: a direction, start, service or non-autofire button change appears at the output exactly 1 cycle after the input change.
- Frame tick: tick=vs & ~vs_d, one cycle wide.
- SOCD cleaning: if left and right are both high, both outputs are inactive; same rule for up/down. Applied before registering.
- Autofire, per player per button, when af_en[b]=1:
  - Idle while the button is released; output inactive; frame counter = 0, phase = 1.
  - On the press cycle the output becomes active on the next clock (phase=1).
  - Each tick while held increments the frame counter. When it reaches AF_FRAMES, phase toggles and the counter returns to 0.
  - On release, output is inactive next cycle and state returns to idle.
  - If af_en falls mid-hold, the button reverts to plain pass-through on the next cycle.
- Coin stretch, per player:
  - Rising edge of board_coin loads the counter with COIN_FRAMES and asserts the output next cycle.
  - Each tick decrements the counter; the output deasserts on the cycle the counter reaches 0.
  - Coin edges while the counter is nonzero are ignored (no retrigger).
  - If an edge and a tick land on the same cycle with the counter at 0, the load wins.
- Pause: a rising edge of player 1 bit 15 toggles pause. Level-held input does not retoggle. Bit 15 of other players is ignored.
- Simultaneous tick and press: the press takes effect (output active, counter 0); the tick in that cycle is not counted.
- Reset asserted mid-pulse or mid-autofire aborts the pulse or autofire immediately; reset values appear on the clock edge where rst is sampled high.
- Counter widths are 4 bits; parameters outside their stated ranges are illegal and caught by an elaboration-time check.

Decomposition:
- Package jtframe_inputs_pkg: bit index constants (RIGHT=0, LEFT=1, DOWN=2, UP=3, BTN0=4, SERVICE=14, PAUSE=15), GAME_JOYW=10, and the 4-bit frame counter typedef.
- Sub-module jtframe_inputs_player: one player's SOCD, autofire and coin stretch. Instantiated PLAYERS times in a generate loop.
- Top level keeps the vs edge detector, the pause toggle, service OR and output polarity.

Test Plan:
1. Reset with ACTIVE_LOW=1, PLAYERS=4 -> game_joy=40'hFF_FFFF_FFFF, game_coin=4'hF, game_start=4'hF, pause=0 on the first post-reset cycle.
2. P2 left+right high, up high -> P2 game_joy[3:0]=4'b0111 (active low: up active only) one cycle later.
3. af_en=2'b01, AF_FRAMES=2, P1 button0 held for 10 ticks -> output active 2 frames, inactive 2 frames, repeating; button1 held steady stays active.
4. COIN_FRAMES=4, P3 coin pulsed 1 cycle, then pulsed again after 2 ticks -> game_coin[2] active for exactly 4 ticks; the second pulse is ignored.
5. P1 bit15 held 3 frames, released, pressed again -> pause 0→1 on the first press, 1→0 on the second press.
6. rst asserted 1 cycle while a coin pulse and autofire are active -> all outputs inactive next cycle; coin not re-emitted after reset while the button is still held.

Source files
------------

// File: rtl/jtframe_inputs_pkg.sv
// Shared constants and types for the N-player input conditioner.
// Bit positions follow the board-side joystick word layout.
package jtframe_inputs_pkg;

  localparam int RIGHT     = 0;
  localparam int LEFT      = 1;
  localparam int DOWN      = 2;
  localparam int UP        = 3;
  localparam int BTN0      = 4;
  localparam int SERVICE   = 14;
  localparam int PAUSE     = 15;
  localparam int GAME_JOYW = 10;

  typedef logic [3:0] frame_cnt_t;

endpackage

// File: rtl/jtframe_inputs_player.sv
// One player channel: SOCD cleaning, per-button autofire and coin stretch.
// Outputs are registered here with the selected polarity.
module jtframe_inputs_player
  import jtframe_inputs_pkg::*;
#(
  parameter int BUTTONS     = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int AF_FRAMES   = 2,
  parameter int COIN_FRAMES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic [15:0]          joy_i,
  input  logic                 coin_i,
  input  logic [BUTTONS-1:0]   af_en_i,
  output logic [GAME_JOYW-1:0] joy_o,
  output logic                 coin_o
);

  localparam frame_cnt_t AF_N   = frame_cnt_t'(AF_FRAMES);
  localparam frame_cnt_t COIN_N = frame_cnt_t'(COIN_FRAMES);
  localparam logic       POL    = (ACTIVE_LOW != 0);

  logic [3:0]           dir;
  logic [BUTTONS-1:0]   btn;
  logic [BUTTONS-1:0]   btn_d;
  logic [BUTTONS-1:0]   held_q;
  logic [BUTTONS-1:0]   ph_q;
  logic [BUTTONS-1:0]   ph_d;
  frame_cnt_t           cnt_q [BUTTONS];
  frame_cnt_t           cnt_d [BUTTONS];
  frame_cnt_t           coin_cnt_q;
  frame_cnt_t           coin_cnt_d;
  logic                 coin_prev_q;
  logic                 coin_q;
  logic [GAME_JOYW-1:0] joy_d;
  logic [GAME_JOYW-1:0] joy_q;
  logic                 unused_hi;

  assign btn       = joy_i[BTN0 +: BUTTONS];
  assign unused_hi = ^joy_i[15:BTN0+BUTTONS];

  always_comb begin
    dir        = '0;
    dir[RIGHT] = joy_i[RIGHT] & ~joy_i[LEFT];
    dir[LEFT]  = joy_i[LEFT]  & ~joy_i[RIGHT];
    dir[DOWN]  = joy_i[DOWN]  & ~joy_i[UP];
    dir[UP]    = joy_i[UP]    & ~joy_i[DOWN];
  end

  // A press cycle restarts the phase, so a tick on that cycle is dropped
  always_comb begin
    ph_d  = ph_q;
    btn_d = btn;
    for (int b = 0; b < BUTTONS; b++) begin
      cnt_d[b] = cnt_q[b];
      if (!af_en_i[b] || !btn[b] || !held_q[b]) begin
        cnt_d[b] = '0;
        ph_d[b]  = 1'b1;
      end else if (tick_i) begin
        if (cnt_q[b] + 4'd1 == AF_N) begin
          cnt_d[b] = '0;
          ph_d[b]  = ~ph_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 4'd1;
        end
      end
      if (af_en_i[b]) btn_d[b] = btn[b] & ph_d[b];
    end
  end

  always_comb begin
    coin_cnt_d = coin_cnt_q;
    if (coin_cnt_q == '0) begin
      if (coin_i && !coin_prev_q) coin_cnt_d = COIN_N;
    end else if (tick_i) begin
      coin_cnt_d = coin_cnt_q - 4'd1;
    end
  end

  always_comb begin
    joy_d                  = '0;
    joy_d[3:0]             = dir;
    joy_d[BTN0 +: BUTTONS] = btn_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_q      <= '0;
      ph_q        <= '1;
      for (int b = 0; b < BUTTONS; b++) cnt_q[b] <= '0;
      coin_cnt_q  <= '0;
      coin_prev_q <= coin_i;
      joy_q       <= {GAME_JOYW{POL}};
      coin_q      <= POL;
    end else begin
      held_q      <= btn;
      ph_q        <= ph_d;
      for (int b = 0; b < BUTTONS; b++) cnt_q[b] <= cnt_d[b];
      coin_cnt_q  <= coin_cnt_d;
      coin_prev_q <= coin_i;
      joy_q       <= joy_d ^ {GAME_JOYW{POL}};
      coin_q      <= (coin_cnt_d != '0) ^ POL;
    end
  end

  assign joy_o  = joy_q;
  assign coin_o = coin_q;

endmodule

// File: rtl/jtframe_inputs_mux.sv
// N-player input conditioner between board controls and the game core.
// Holds the frame tick, pause toggle, service OR and start registers.
module jtframe_inputs_mux
  import jtframe_inputs_pkg::*;
#(
  parameter int PLAYERS     = 4,
  parameter int BUTTONS     = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int AF_FRAMES   = 2,
  parameter int COIN_FRAMES = 4
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic                         vs,
  input  logic [PLAYERS*16-1:0]        board_joy,
  input  logic [PLAYERS-1:0]           board_coin,
  input  logic [PLAYERS-1:0]           board_start,
  input  logic [BUTTONS-1:0]           af_en,
  output logic [PLAYERS*GAME_JOYW-1:0] game_joy,
  output logic [PLAYERS-1:0]           game_coin,
  output logic [PLAYERS-1:0]           game_start,
  output logic                         game_service,
  output logic                         pause
);

  localparam logic POL = (ACTIVE_LOW != 0);

  if (PLAYERS < 1 || PLAYERS > 8 ||
      BUTTONS < 1 || BUTTONS > 6 ||
      AF_FRAMES < 1 || AF_FRAMES > 15 ||
      COIN_FRAMES < 1 || COIN_FRAMES > 15 ||
      ACTIVE_LOW < 0 || ACTIVE_LOW > 1) begin : g_bad_param
    $error("jtframe_inputs_mux: parameter out of range");
  end

  logic               vs_q;
  logic               tick;
  logic               pp_q;
  logic               pause_q;
  logic               pause_d;
  logic               srv_d;
  logic               srv_q;
  logic [PLAYERS-1:0] start_q;

  assign tick    = vs & ~vs_q;
  assign pause_d = pause_q ^ (board_joy[PAUSE] & ~pp_q);

  always_comb begin
    srv_d = 1'b0;
    for (int p = 0; p < PLAYERS; p++) srv_d = srv_d | board_joy[p*16+SERVICE];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      vs_q    <= vs;
      pp_q    <= board_joy[PAUSE];
      pause_q <= 1'b0;
      srv_q   <= POL;
      start_q <= {PLAYERS{POL}};
    end else begin
      vs_q    <= vs;
      pp_q    <= board_joy[PAUSE];
      pause_q <= pause_d;
      srv_q   <= srv_d ^ POL;
      start_q <= board_start ^ {PLAYERS{POL}};
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    jtframe_inputs_player #(
      .BUTTONS    (BUTTONS),
      .ACTIVE_LOW (ACTIVE_LOW),
      .AF_FRAMES  (AF_FRAMES),
      .COIN_FRAMES(COIN_FRAMES)
    ) u_player (
      .clk_i  (clk_sys),
      .rst_i  (rst),
      .tick_i (tick),
      .joy_i  (board_joy[p*16 +: 16]),
      .coin_i (board_coin[p]),
      .af_en_i(af_en),
      .joy_o  (game_joy[p*GAME_JOYW +: GAME_JOYW]),
      .coin_o (game_coin[p])
    );
  end

  assign game_start   = start_q;
  assign game_service = srv_q;
  assign pause        = pause_q;

endmodule
